sysid_regs: RTL and testbench

- Parametrised Avalon-MM system-identification slave, the second generation of the per-system sysid block.
- Beyond the constant ID and TIMESTAMP words, it adds:
  - a byte-writable scratch register;
  - a control register;
  - a free-running uptime counter read through a coherent 64-bit snapshot;
  - a capability word.
- Reads are registered with fixed latency 1 and signalled by readdatavalid.
- Sits on the system interconnect; software uses it for system identification, bus sanity checks and coarse time measurement.

---
 rtl/sysid_regs_if.sv | 21 ++
 rtl/sysid_regs.sv | 113 +++++++++++
 tb/tb_sysid_regs.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_regs_if.sv
// Avalon-MM slave bus bundle for the sysid register block.
// The master drives the request side; the slave returns registered read data.
interface sysid_regs_if;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/sysid_regs.sv
// Second-generation system-identification slave: constant ID/TIMESTAMP words,
// scratch and control registers, and a free-running uptime counter with a coherent 64-bit snapshot.
module sysid_regs #(
    parameter logic [31:0] SYS_ID       = 32'h0000_0001,
    parameter logic [31:0] TIMESTAMP    = 32'd1432487389,
    parameter int unsigned CNT_WIDTH    = 64,
    parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000
) (
    input  logic         clock,
    input  logic         reset,
    sysid_regs_if.slave  bus
);

    typedef enum logic [2:0] {
        ADDR_ID        = 3'd0,
        ADDR_TS        = 3'd1,
        ADDR_SCRATCH   = 3'd2,
        ADDR_CTRL      = 3'd3,
        ADDR_UPTIME_LO = 3'd4,
        ADDR_UPTIME_HI = 3'd5,
        ADDR_RESERVED  = 3'd6,
        ADDR_CAPS      = 3'd7
    } addr_e;

    localparam logic [7:0]  BLOCK_VERSION = 8'h02;
    localparam logic [31:0] CAPS_WORD     = {16'h0000, BLOCK_VERSION, 8'(CNT_WIDTH)};

    logic [31:0]          scratch_q, scratch_d;
    logic                 en_q, en_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]          shadow_q, shadow_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 rvalid_q;

    logic wr_scratch;
    logic wr_ctrl;
    logic rd_lo;

    assign wr_scratch = bus.write && (bus.address == ADDR_SCRATCH);
    assign wr_ctrl    = bus.write && (bus.address == ADDR_CTRL);
    assign rd_lo      = bus.read  && (bus.address == ADDR_UPTIME_LO);

    // NOTE: every signal assigned in an always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        scratch_d = scratch_q;
        if (wr_scratch) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.byteenable[i]) begin
                    scratch_d[8*i +: 8] = bus.writedata[8*i +: 8];
                end
            end
        end
    end

    // clr beats the increment; the en bit from the same word governs later cycles.
    always_comb begin
        en_d  = wr_ctrl ? bus.writedata[0] : en_q;
        cnt_d = cnt_q;
        if (wr_ctrl && bus.writedata[1]) begin
            cnt_d = '0;
        end else if (en_q) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // The upper word is latched only by a LO read so a LO/HI pair is coherent across a carry.
    always_comb begin
        shadow_d = shadow_q;
        if (rd_lo) begin
            shadow_d = 32'(cnt_q[CNT_WIDTH-1:32]);
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (bus.read) begin
            case (bus.address)
                ADDR_ID:        rdata_d = SYS_ID;
                ADDR_TS:        rdata_d = TIMESTAMP;
                ADDR_SCRATCH:   rdata_d = scratch_q;
                ADDR_CTRL:      rdata_d = {31'b0, en_q};
                ADDR_UPTIME_LO: rdata_d = cnt_q[31:0];
                ADDR_UPTIME_HI: rdata_d = shadow_q;
                ADDR_CAPS:      rdata_d = CAPS_WORD;
                default:        rdata_d = 32'h0000_0000;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            scratch_q <= SCRATCH_INIT;
            en_q      <= 1'b1;
            cnt_q     <= '0;
            shadow_q  <= 32'h0000_0000;
            rdata_q   <= 32'h0000_0000;
            rvalid_q  <= 1'b0;
        end else begin
            scratch_q <= scratch_d;
            en_q      <= en_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= bus.read;
        end
    end

    // A read accepted just before reset must not signal valid during the reset cycle itself.
    assign bus.readdata      = rdata_q;
    assign bus.readdatavalid = rvalid_q & ~reset;

endmodule

// File: tb/tb_sysid_regs.sv
// Scoreboard bench for sysid_regs: drivers push expected read data, negedge monitors pop and compare.
// A 64-bit instance covers the full map; a 33-bit instance covers narrow-counter wrap.
module tb_sysid_regs;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        string       name;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    exp_t q64[$];
    exp_t q33[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    sysid_regs_if bus ();
    sysid_regs_if bus33 ();

    sysid_regs #(.CNT_WIDTH(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    sysid_regs #(.CNT_WIDTH(33)) dut33 (
        .clock (clock),
        .reset (reset),
        .bus   (bus33)
    );

    // Reference uptime model for the 64-bit instance (en, clr, wrap, shadow).
    logic [63:0] m_cnt;
    logic [31:0] m_shadow;
    logic        m_en;
    logic        load64;
    logic [63:0] load_val64;

    always @(posedge clock) begin
        if (reset) begin
            m_cnt    <= 64'd0;
            m_en     <= 1'b1;
            m_shadow <= 32'd0;
        end else begin
            if (load64) begin
                m_cnt <= load_val64 + 64'd1;
            end else if (bus.write && bus.address == 3'd3) begin
                m_en  <= bus.writedata[0];
                m_cnt <= bus.writedata[1] ? 64'd0 : (m_en ? m_cnt + 64'd1 : m_cnt);
            end else if (m_en) begin
                m_cnt <= m_cnt + 64'd1;
            end
            if (bus.read && bus.address == 3'd4) m_shadow <= m_cnt[63:32];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (bus.readdatavalid === 1'b1) begin
            if (q64.size() == 0) begin
                check("unexpected_valid64", 32'd1, 32'd0);
            end else begin
                e = q64.pop_front();
                check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc + 1));
                check(e.name, bus.readdata, e.data);
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (bus33.readdatavalid === 1'b1) begin
            if (q33.size() == 0) begin
                check("unexpected_valid33", 32'd1, 32'd0);
            end else begin
                e = q33.pop_front();
                check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc + 1));
                check(e.name, bus33.readdata, e.data);
            end
        end
    end

    task automatic begin_cycle();
        @(negedge clock);
        #1;
        load64      = 1'b0;
        bus.read    = 1'b0;
        bus.write   = 1'b0;
        bus33.read  = 1'b0;
        bus33.write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin_cycle();
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        begin_cycle();
        bus.address = a;
        bus.read    = 1'b1;
        q64.push_back('{data: exp, cyc: cyc, name: name});
    endtask

    // Expected LO/HI value comes from the model state at issue time.
    task automatic rd_model(input logic [2:0] a, input string name);
        begin_cycle();
        bus.address = a;
        bus.read    = 1'b1;
        q64.push_back('{data: (a == 3'd4) ? m_cnt[31:0] : m_shadow, cyc: cyc, name: name});
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        begin_cycle();
        bus.address    = a;
        bus.write      = 1'b1;
        bus.writedata  = d;
        bus.byteenable = be;
    endtask

    task automatic rdwr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic [31:0] exp, input string name);
        begin_cycle();
        bus.address    = a;
        bus.read       = 1'b1;
        bus.write      = 1'b1;
        bus.writedata  = d;
        bus.byteenable = be;
        q64.push_back('{data: exp, cyc: cyc, name: name});
    endtask

    task automatic rd33(input logic [2:0] a, input logic [31:0] exp, input string name);
        begin_cycle();
        bus33.address = a;
        bus33.read    = 1'b1;
        q33.push_back('{data: exp, cyc: cyc, name: name});
    endtask

    // Counter holds v for the rest of this cycle, so it reads v+1 from the next cycle on.
    task automatic force64(input logic [63:0] v);
        begin_cycle();
        load_val64 = v;
        load64     = 1'b1;
        force dut.cnt_q = v;
        #1 release dut.cnt_q;
    endtask

    task automatic force33(input logic [32:0] v);
        begin_cycle();
        force dut33.cnt_q = v;
        #1 release dut33.cnt_q;
    endtask

    initial begin
        reset            = 1'b1;
        load64           = 1'b0;
        load_val64       = 64'd0;
        bus.address      = 3'd0;
        bus.read         = 1'b0;
        bus.write        = 1'b0;
        bus.writedata    = 32'd0;
        bus.byteenable   = 4'h0;
        bus33.address    = 3'd0;
        bus33.read       = 1'b0;
        bus33.write      = 1'b0;
        bus33.writedata  = 32'd0;
        bus33.byteenable = 4'h0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_readdata", bus.readdata, 32'd0);
        check("reset_valid", {31'd0, bus.readdatavalid}, 32'd0);
        #1 reset = 1'b0;

        // Constant words, back-to-back.
        rd(3'd0, 32'h0000_0001, "id");
        rd(3'd1, 32'd1432487389, "timestamp");
        rd(3'd7, 32'h0000_0240, "caps64");
        idle(2);
        check("readdata_hold", bus.readdata, 32'h0000_0240);

        // Scratch byte lanes, RO protection, reserved, read-during-write.
        wr(3'd2, 32'hDEAD_BEEF, 4'hF);
        wr(3'd2, 32'h0000_0011, 4'b0001);
        rd(3'd2, 32'hDEAD_BE11, "scratch_bytelane");
        wr(3'd0, 32'hFFFF_FFFF, 4'hF);
        wr(3'd7, 32'hFFFF_FFFF, 4'hF);
        wr(3'd6, 32'hFFFF_FFFF, 4'hF);
        rd(3'd0, 32'h0000_0001, "id_after_write");
        rd(3'd7, 32'h0000_0240, "caps_after_write");
        rd(3'd6, 32'h0000_0000, "reserved");
        rdwr(3'd2, 32'h1234_5678, 4'hF, 32'hDEAD_BE11, "scratch_rd_during_wr");
        rd(3'd2, 32'h1234_5678, "scratch_after_wr");
        wr(3'd2, 32'hAA00_0000, 4'b1000);
        rd(3'd2, 32'hAA34_5678, "scratch_top_lane");

        // Counter hold, clear, readback of CTRL.
        wr(3'd3, 32'h0000_0000, 4'hF);
        idle(100);
        rd_model(3'd4, "lo_hold_a");
        rd_model(3'd4, "lo_hold_b");
        rd(3'd3, 32'h0000_0000, "ctrl_disabled");
        wr(3'd3, 32'h0000_0003, 4'hF);
        rd_model(3'd4, "lo_after_clr_a");
        rd_model(3'd4, "lo_after_clr_b");
        rd(3'd3, 32'h0000_0001, "ctrl_readback");
        wr(3'd3, 32'hFFFF_FFFD, 4'hF);
        rd(3'd3, 32'h0000_0001, "ctrl_upper_ignored");
        idle(3);

        // Snapshot coherence across a carry out of bit 31.
        force64(64'h0000_0000_FFFF_FFFE);
        rd(3'd4, 32'hFFFF_FFFF, "lo_before_carry");
        rd(3'd5, 32'h0000_0000, "hi_coherent");
        rd(3'd4, 32'h0000_0001, "lo_after_carry");
        rd(3'd5, 32'h0000_0001, "hi_after_carry");
        idle(2);

        // 33-bit counter wraps to zero; HI only ever 0 or 1.
        rd33(3'd7, 32'h0000_0221, "caps33");
        force33(33'h1_FFFF_FFFE);
        rd33(3'd4, 32'hFFFF_FFFF, "lo33_top");
        rd33(3'd5, 32'h0000_0001, "hi33_top");
        rd33(3'd4, 32'h0000_0001, "lo33_wrapped");
        rd33(3'd5, 32'h0000_0000, "hi33_wrapped");
        idle(2);

        // Reset with a read in flight and modified registers.
        wr(3'd2, 32'hA5A5_A5A5, 4'hF);
        wr(3'd3, 32'h0000_0000, 4'hF);
        begin_cycle();
        bus.address = 3'd2;
        bus.read    = 1'b1;
        @(posedge clock);
        #1;
        bus.read = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        check("valid_in_reset", {31'd0, bus.readdatavalid}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("readdata_after_reset", bus.readdata, 32'd0);
        rd(3'd2, 32'h0000_0000, "scratch_after_reset");
        rd(3'd3, 32'h0000_0001, "ctrl_after_reset");
        rd_model(3'd4, "lo_after_reset");
        idle(4);

        check("pending64", 32'(q64.size()), 32'd0);
        check("pending33", 32'(q33.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
